bus_hold_arbiter: RTL

Shares the 8088 local bus between the CPU and up to N_REQ bus-master requesters (DMA-style engines) by sequencing the processor's HOLD/HLDA handshake. It sits beside the Intel8088 model and the memory/IO controller FSM. It drives HOLD into the CPU, watches HLDA, and grants the bus to one requester at a time with round-robin priority. Tenure is bounded, and a minimum CPU-owned gap is enforced between tenures.

---
 rtl/bus_hold_arbiter_if.sv | 11 +
 rtl/bus_hold_arbiter.sv | 95 +++++++++
 2 files changed

// File: rtl/bus_hold_arbiter_if.sv
// bus_hold_arbiter_if: requester/CPU hold-handshake bundle for the bus arbiter
interface bus_hold_arbiter_if #(parameter int N_REQ = 2);
  logic [N_REQ-1:0] REQ;
  logic HLDA;
  logic HOLD;
  logic [N_REQ-1:0] GNT;
  logic [1:0] OWNER;
  logic EXPIRED;
  modport master (input REQ, HLDA, output HOLD, GNT, OWNER, EXPIRED);
  modport slave (output REQ, HLDA, input HOLD, GNT, OWNER, EXPIRED);
endinterface

// File: rtl/bus_hold_arbiter.sv
// bus_hold_arbiter: round-robin HOLD/HLDA bus sharing with bounded tenure and a CPU gap
module bus_hold_arbiter #(
  parameter int N_REQ = 2,
  parameter int MAX_TENURE = 64,
  parameter int MIN_CPU_GAP = 4
) (
  input logic CLK,
  input logic RESET_N,
  bus_hold_arbiter_if.master bus
);
  localparam int TW = $clog2(MAX_TENURE) + 1;
  localparam int GW = $clog2(MIN_CPU_GAP) + 1;
  typedef enum logic [2:0] {IDLE, HOLD_REQ, GRANT, RELEASE, GAP} state_t;
  state_t state, state_n;
  logic [1:0] ptr, ptr_n, owner_n, win;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [GW-1:0] gcnt, gcnt_n;
  logic hold_n, expired_n, own_req;
  logic [N_REQ-1:0] gnt_n, own_oh, rot;
  assign own_oh = N_REQ'(1) << bus.OWNER;
  assign own_req = |(bus.REQ & own_oh);
  assign rot = N_REQ'({bus.REQ, bus.REQ} >> ptr);
  // first pending requester at or above the pointer, wrapping
  always_comb begin
    win = ptr;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (rot[i]) win = 2'((int'(ptr) + i) % N_REQ);
  end
  // next state and next values of the registered outputs
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    owner_n = bus.OWNER;
    tcnt_n = tcnt;
    gcnt_n = gcnt;
    hold_n = bus.HOLD;
    gnt_n = bus.GNT;
    expired_n = 1'b0;
    case (state)
      IDLE: if (|bus.REQ && !bus.HLDA) begin
        owner_n = win;
        hold_n = 1'b1;
        state_n = HOLD_REQ;
      end
      HOLD_REQ: if (!own_req) begin
        hold_n = 1'b0;
        state_n = RELEASE;
      end else if (bus.HLDA) begin
        gnt_n = own_oh;
        tcnt_n = '0;
        state_n = GRANT;
      end
      GRANT: begin
        tcnt_n = tcnt + TW'(1);
        if (!own_req || tcnt == TW'(MAX_TENURE - 1)) begin
          gnt_n = '0;
          hold_n = 1'b0;
          ptr_n = (bus.OWNER == 2'(N_REQ - 1)) ? 2'd0 : bus.OWNER + 2'd1;
          expired_n = own_req;
          state_n = RELEASE;
        end
      end
      RELEASE: if (!bus.HLDA) begin
        gcnt_n = '0;
        state_n = (MIN_CPU_GAP == 0) ? IDLE : GAP;
      end
      GAP: if (!bus.HLDA) begin
        gcnt_n = gcnt + GW'(1);
        state_n = (gcnt_n == GW'(MIN_CPU_GAP)) ? IDLE : GAP;
      end
      default: state_n = IDLE;
    endcase
  end
  // state, counters and outputs; reset leaves the CPU gap already satisfied
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state <= IDLE;
      ptr <= '0;
      tcnt <= '0;
      gcnt <= GW'(MIN_CPU_GAP);
      bus.HOLD <= 1'b0;
      bus.GNT <= '0;
      bus.OWNER <= '0;
      bus.EXPIRED <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      tcnt <= tcnt_n;
      gcnt <= gcnt_n;
      bus.HOLD <= hold_n;
      bus.GNT <= gnt_n;
      bus.OWNER <= owner_n;
      bus.EXPIRED <= expired_n;
    end
endmodule
